regfile_write_bank: RTL



---
 rtl/reg_pkg.sv | 10 +
 rtl/regfile_write_bank_decoder5x32.sv | 13 +
 rtl/regfile_write_bank.sv | 71 +++++++
 3 files changed

// File: rtl/reg_pkg.sv
// Shared types and constants for the integer register file write side.
package reg_pkg;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef logic [4:0]                  regAddr_t;
  typedef logic [XLEN-1:0]             regWord_t;
  typedef logic [XLEN-1:0][NREGS-1:0]  regSliced_t;
endpackage

// File: rtl/regfile_write_bank_decoder5x32.sv
// 5-to-32 one-hot decoder; output is all zero while en is low.
module decoder5x32
  import reg_pkg::*;
(
  input  logic       en,
  input  regAddr_t   addr,
  output logic [31:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end
endmodule

// File: rtl/regfile_write_bank.sv
// Register file write side: 31 stored 64-bit registers plus hardwired zero,
// bit-sliced storage export, and a per-register busy scoreboard.
module regfile_write_bank
  import reg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wrEn,
  input  regAddr_t   wrAddr,
  input  regWord_t   wrData,
  input  logic       markEn,
  input  regAddr_t   markAddr,
  input  regAddr_t   chkAddrA,
  input  regAddr_t   chkAddrB,
  output regSliced_t regBits,
  output logic [NREGS-1:0] busy,
  output logic       hazard
);
  logic [NREGS-1:0] wr_sel;
  logic [NREGS-1:0] mark_sel;
  regWord_t         regs [NREGS];

  decoder5x32 u_wr_dec (
    .en     (wrEn),
    .addr   (wrAddr),
    .onehot (wr_sel)
  );

  decoder5x32 u_mark_dec (
    .en     (markEn),
    .addr   (markAddr),
    .onehot (mark_sel)
  );

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == int'(ZERO_REG)) begin : g_zero
      // XZR has no storage; its decode lines are intentionally dropped.
      logic unused_zero_sel;
      assign unused_zero_sel = wr_sel[r] | mark_sel[r];
      assign regs[r] = '0;
      assign busy[r] = 1'b0;
    end else begin : g_live
      regWord_t q;
      logic     busy_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          q      <= '0;
          busy_q <= 1'b0;
        end else begin
          if (wr_sel[r]) q <= wrData;
          // A newly issued producer supersedes the one retiring this cycle.
          if (mark_sel[r])    busy_q <= 1'b1;
          else if (wr_sel[r]) busy_q <= 1'b0;
        end
      end
      assign regs[r] = q;
      assign busy[r] = busy_q;
    end
  end

  always_comb begin
    regBits = '0;
    for (int b = 0; b < XLEN; b++) begin
      for (int r = 0; r < NREGS; r++) begin
        regBits[b][r] = regs[r][b];
      end
    end
  end

  assign hazard = busy[chkAddrA] | busy[chkAddrB];
endmodule
